// File: rtl/int_arbiter.sv
// Interrupt arbiter: synchronizes reset/NMI/IRQ requests, picks a winner by fixed
// priority and offers exactly one request at a time to the CPU status unit.
module int_arbiter #(
  parameter int N_IRQ   = 4,
  parameter int HOLDOFF = 3,
  localparam int IDX_W  = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             nmi_n,
  input  logic [N_IRQ-1:0] irq_n,
  input  logic             rst_req,
  input  logic             cfg_we,
  input  logic [N_IRQ-1:0] cfg_data,
  input  logic             int_ack,
  output logic             rst,
  output logic             nmi,
  output logic             irq,
  output logic [IDX_W-1:0] irq_src,
  output logic [N_IRQ-1:0] irq_pending
);

  typedef enum logic [1:0] {IDLE, OFFER, HOLD} state_e;
  typedef enum logic [1:0] {G_RST, G_NMI, G_IRQ} grant_e;

  localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF);

  // Lower value means higher priority; IRQs rank by index below RST and NMI.
  function automatic logic [3:0] prio_of(grant_e kind, logic [IDX_W-1:0] idx);
    case (kind)
      G_RST:   return 4'd0;
      G_NMI:   return 4'd1;
      default: return 4'd2 + 4'(idx);
    endcase
  endfunction

  logic             nmi_s1, nmi_s2, nmi_prev;
  logic [2:0]       nmi_armed;
  logic [N_IRQ-1:0] irq_s1, irq_s2;
  logic [N_IRQ-1:0] irq_en;
  logic             rst_pend, nmi_pend;
  logic             nmi_fall;

  state_e           state, state_nxt;
  grant_e           grant_kind, grant_kind_nxt;
  logic [IDX_W-1:0] grant_idx, grant_idx_nxt;
  logic [3:0]       hold_cnt, hold_cnt_nxt;
  logic [IDX_W-1:0] irq_src_nxt;
  logic             clr_rst, clr_nmi;

  grant_e           win_kind;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;

  // The edge detector only arms once the synchronizer holds real samples, so
  // releasing a_rst with nmi_n already low never looks like a falling edge.
  assign nmi_fall    = nmi_armed[2] & nmi_prev & ~nmi_s2;
  assign irq_pending = ~irq_s2 & irq_en;

  // NOTE: every flop uses non-blocking assignments so all state updates on an
  // edge see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      nmi_s1    <= 1'b1;
      nmi_s2    <= 1'b1;
      nmi_prev  <= 1'b1;
      nmi_armed <= '0;
      irq_s1    <= '1;
      irq_s2    <= '1;
      irq_en    <= '0;
      rst_pend  <= 1'b0;
      nmi_pend  <= 1'b0;
    end else begin
      nmi_s1    <= nmi_n;
      nmi_s2    <= nmi_s1;
      nmi_prev  <= nmi_s2;
      nmi_armed <= {nmi_armed[1:0], 1'b1};
      irq_s1    <= irq_n;
      irq_s2    <= irq_s1;
      if (cfg_we) irq_en <= cfg_data;
      // A new event in the same cycle as a clear wins, so no event is lost.
      rst_pend  <= rst_req  | (rst_pend & ~clr_rst);
      nmi_pend  <= nmi_fall | (nmi_pend & ~clr_nmi);
    end
  end

  always_comb begin
    win_kind  = G_IRQ;
    win_idx   = '0;
    win_valid = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (irq_pending[i]) begin
        win_idx   = IDX_W'(i);
        win_valid = 1'b1;
      end
    end
    if (nmi_pend) begin
      win_kind  = G_NMI;
      win_valid = 1'b1;
    end
    if (rst_pend) begin
      win_kind  = G_RST;
      win_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state      <= IDLE;
      grant_kind <= G_RST;
      grant_idx  <= '0;
      hold_cnt   <= '0;
      irq_src    <= '0;
    end else begin
      state      <= state_nxt;
      grant_kind <= grant_kind_nxt;
      grant_idx  <= grant_idx_nxt;
      hold_cnt   <= hold_cnt_nxt;
      irq_src    <= irq_src_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    grant_kind_nxt = grant_kind;
    grant_idx_nxt  = grant_idx;
    hold_cnt_nxt   = hold_cnt;
    irq_src_nxt    = irq_src;
    clr_rst        = 1'b0;
    clr_nmi        = 1'b0;
    rst            = 1'b0;
    nmi            = 1'b0;
    irq            = 1'b0;

    case (state)
      IDLE: begin
        if (win_valid) begin
          grant_kind_nxt = win_kind;
          grant_idx_nxt  = win_idx;
          state_nxt      = OFFER;
        end
      end

      OFFER: begin
        rst = (grant_kind == G_RST);
        nmi = (grant_kind == G_NMI);
        irq = (grant_kind == G_IRQ);
        if (int_ack) begin
          clr_rst      = (grant_kind == G_RST);
          clr_nmi      = (grant_kind == G_NMI);
          if (grant_kind == G_IRQ) irq_src_nxt = grant_idx;
          hold_cnt_nxt = HOLD_INIT;
          state_nxt    = HOLD;
        end else if (win_valid &&
                     prio_of(win_kind, win_idx) < prio_of(grant_kind, grant_idx)) begin
          grant_kind_nxt = win_kind;
          grant_idx_nxt  = win_idx;
        end else if (grant_kind == G_IRQ && !irq_pending[grant_idx]) begin
          state_nxt = IDLE;
        end
      end

      HOLD: begin
        hold_cnt_nxt = hold_cnt - 4'd1;
        if (hold_cnt <= 4'd1) begin
          hold_cnt_nxt = '0;
          state_nxt    = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_int_arbiter.sv
// Directed bench for int_arbiter: NMI latency, IRQ masking/priority, pre-emption,
// source loss, reset-vs-NMI ordering and asynchronous reset during an offer.
module tb_int_arbiter;

  localparam int N_IRQ = 4;

  logic             clk = 1'b0;
  logic             a_rst;
  logic             nmi_n;
  logic [N_IRQ-1:0] irq_n;
  logic             rst_req, cfg_we, int_ack;
  logic [N_IRQ-1:0] cfg_data;
  logic             rst, nmi, irq;
  logic [1:0]       irq_src;
  logic [N_IRQ-1:0] irq_pending;

  int n_cmp = 0;
  int n_err = 0;

  int_arbiter #(.N_IRQ(N_IRQ), .HOLDOFF(3)) dut (
    .clk        (clk),
    .a_rst      (a_rst),
    .nmi_n      (nmi_n),
    .irq_n      (irq_n),
    .rst_req    (rst_req),
    .cfg_we     (cfg_we),
    .cfg_data   (cfg_data),
    .int_ack    (int_ack),
    .rst        (rst),
    .nmi        (nmi),
    .irq        (irq),
    .irq_src    (irq_src),
    .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled on falling edges.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, rst, nmi, irq}, {29'd0, exp});
  endtask

  initial begin
    a_rst    = 1'b0;
    nmi_n    = 1'b1;
    irq_n    = '1;
    rst_req  = 1'b0;
    cfg_we   = 1'b0;
    cfg_data = '0;
    int_ack  = 1'b0;

    tick(2);
    check_outs("reset_outs", 3'b000);
    check("reset_src", 32'(irq_src), 32'd0);
    check("reset_pend", 32'(irq_pending), 32'd0);
    a_rst = 1'b1;
    tick(4);

    // NMI latency: nmi high only after the third edge following the first low sample
    nmi_n = 1'b0;
    tick(1); check_outs("nmi_lat_n0", 3'b000);
    tick(1); check_outs("nmi_lat_n1", 3'b000);
    tick(1); check_outs("nmi_lat_n2", 3'b000);
    tick(1); check_outs("nmi_lat_n3", 3'b010);
    int_ack = 1'b1;
    tick(1); int_ack = 1'b0; nmi_n = 1'b1;
    check_outs("nmi_ack_drop", 3'b000);
    tick(1); check_outs("nmi_hold1", 3'b000);
    tick(1); check_outs("nmi_hold2", 3'b000);
    tick(1); check_outs("nmi_idle", 3'b000);
    tick(1); check_outs("nmi_no_retrigger", 3'b000);

    // Masked IRQs: enable 0110, lines 0 and 3 inactive -> lowest enabled active is 1
    cfg_we = 1'b1; cfg_data = 4'b0110; irq_n = 4'b1001;
    tick(1); cfg_we = 1'b0;
    check("irq_pend_sync", 32'(irq_pending), 32'd0);
    tick(1);
    check("irq_pend", 32'(irq_pending), 32'b0110);
    check_outs("irq_pre_offer", 3'b000);
    tick(1); check_outs("irq_offer", 3'b001);
    int_ack = 1'b1;
    tick(1); int_ack = 1'b0;
    check("irq_src_ack", 32'(irq_src), 32'd1);
    check_outs("irq_hold0", 3'b000);
    tick(3); check_outs("irq_holdoff_end", 3'b000);
    tick(1); check_outs("irq_reoffer", 3'b001);

    // NMI pre-empts the offered IRQ with no overlap
    nmi_n = 1'b0;
    tick(3); check_outs("preempt_before", 3'b001);
    tick(1); check_outs("preempt_switch", 3'b010);
    int_ack = 1'b1;
    tick(1); int_ack = 1'b0; nmi_n = 1'b1;
    check_outs("preempt_ack", 3'b000);
    check("preempt_src_kept", 32'(irq_src), 32'd1);
    tick(3); check_outs("preempt_hold", 3'b000);
    tick(1); check_outs("preempt_nmi_cleared", 3'b001);

    // IRQ line released before acknowledge: offer withdrawn within 3 cycles
    irq_n = 4'b1111;
    begin
      int waited = 0;
      while (irq !== 1'b0 && waited < 3) begin
        tick(1);
        waited++;
      end
    end
    check("release_irq_low", 32'(irq), 32'd0);
    tick(2);
    check_outs("release_idle", 3'b000);
    check("release_src_kept", 32'(irq_src), 32'd1);

    // Active line with its enable clear is never pending
    irq_n = 4'b1110;
    tick(3);
    check("mask_pend", 32'(irq_pending), 32'd0);
    check_outs("mask_outs", 3'b000);
    irq_n = 4'b1111;
    tick(3);

    // rst_req and NMI pend flags set on the same edge: RST first, then NMI
    nmi_n = 1'b0;
    tick(2); rst_req = 1'b1;
    tick(1); rst_req = 1'b0;
    check_outs("rstnmi_idle", 3'b000);
    tick(1); check_outs("rstnmi_rst_first", 3'b100);
    int_ack = 1'b1;
    tick(1); int_ack = 1'b0; nmi_n = 1'b1;
    check_outs("rstnmi_ack", 3'b000);
    tick(3); check_outs("rstnmi_hold", 3'b000);
    tick(1); check_outs("rstnmi_nmi_next", 3'b010);
    int_ack = 1'b1;
    tick(1); int_ack = 1'b0;
    check_outs("rstnmi_nmi_ack", 3'b000);
    tick(5); check_outs("rstnmi_quiet", 3'b000);

    // Asynchronous reset in the middle of an IRQ offer
    irq_n = 4'b1011;
    tick(3);
    check("areset_pre_pend", 32'(irq_pending), 32'b0100);
    check_outs("areset_pre_offer", 3'b001);
    nmi_n = 1'b0;
    #2 a_rst = 1'b0;
    #1;
    check_outs("areset_async_outs", 3'b000);
    check("areset_async_pend", 32'(irq_pending), 32'd0);
    check("areset_async_src", 32'(irq_src), 32'd0);
    @(negedge clk);
    a_rst = 1'b1;
    tick(6);
    check_outs("areset_after_outs", 3'b000);
    check("areset_after_pend", 32'(irq_pending), 32'd0);
    nmi_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/int_arbiter.md
INT_ARBITER -- requirements
Module: int_arbiter

Interface
REQ-001 Parameter N_IRQ, default 4: number of maskable IRQ sources (2..8).
REQ-002 Parameter HOLDOFF, default 3: cycles all requests stay low after an acknowledged grant (1..15).
REQ-003 Signal clk  in  1  clock; all state updates on the rising edge.
REQ-004 Signal a_rst  in  1  asynchronous, active-low reset.
REQ-005 Signal nmi_n  in  1  asynchronous NMI pin, active low, falling-edge triggered.
REQ-006 Signal irq_n  in  N_IRQ  asynchronous IRQ pins, active low, level triggered.
REQ-007 Signal rst_req  in  1  synchronous soft-reset request pulse.
REQ-008 Signal cfg_we  in  1  write strobe for the enable register.
REQ-009 Signal cfg_data  in  N_IRQ  new IRQ enable mask.
REQ-010 Signal int_ack  in  1  one-cycle pulse from the CPU status unit: the offered request is accepted.
REQ-011 Signal rst  out  1  reset request to the CPU status unit.
REQ-012 Signal nmi  out  1  NMI request to the CPU status unit.
REQ-013 Signal irq  out  1  IRQ request to the CPU status unit.
REQ-014 Signal irq_src  out  clog2(N_IRQ)  index of the last acknowledged IRQ source.
REQ-015 Signal irq_pending  out  N_IRQ  synchronized, enabled, active IRQ lines.

Function
REQ-016 nmi_n and each irq_n bit SHALL pass through a two-flop synchronizer.
REQ-017 A synchronized nmi_n high-to-low transition SHALL set nmi_pend; rst_req SHALL set rst_pend.
REQ-018 irq_pending SHALL equal the active synchronized irq lines ANDed with irq_en; IRQs are never latched.
REQ-019 irq_en SHALL load cfg_data when cfg_we is high; the new mask applies from the next cycle.
REQ-020 Priority SHALL be rst_pend > nmi_pend > any irq_pending; among IRQs the lowest index wins.
REQ-021 FSM states SHALL be IDLE, OFFER and HOLD.
REQ-022 IDLE: when any request is pending, register the winning grant (RST/NMI/IRQ plus index) and enter OFFER.
REQ-023 OFFER: exactly one of rst/nmi/irq SHALL be high, decoded from the registered grant; the outputs are otherwise low.
REQ-024 OFFER without int_ack: if a higher-priority request is pending, regrant to it (same state); if an IRQ grant loses its source (line or enable), return to IDLE.
REQ-025 OFFER with int_ack: clear the granted pend flag (RST or NMI); on an IRQ grant load irq_src with the grant index; load holdoff counter = HOLDOFF; enter HOLD.
REQ-026 HOLD: rst/nmi/irq SHALL be low; decrement the counter each cycle; enter IDLE when it reaches 1.
REQ-027 Set and clear of a pend flag in the same cycle SHALL leave it set (a new event is never lost).
REQ-028 NMI edges arriving while nmi_pend is already set SHALL merge into one request.
REQ-029 int_ack outside OFFER SHALL be ignored.
REQ-030 irq_src SHALL stay stable between IRQ acknowledges.
REQ-031 NMI latency: with N = the first edge sampling nmi_n low, nmi_pend is set at N+2 and nmi is high after N+3, given the FSM was IDLE.

Reset
REQ-032 a_rst low SHALL asynchronously force: state IDLE; rst/nmi/irq 0; irq_src 0; irq_en 0; pend flags 0; counter 0; synchronizer flops 1 (inactive).
REQ-033 Deasserting a_rst while nmi_n is low SHALL NOT create an NMI edge.
REQ-034 a_rst asserted mid-OFFER or mid-HOLD SHALL drop all requests immediately, with no pending state retained.

Verification
REQ-035 nmi_n falls at edge N with FSM IDLE -> nmi=1 after N+3; int_ack pulse -> nmi=0 next cycle; no new request for 3 cycles.
REQ-036 irq_en=4'b0110, irq_n=4'b1001 -> irq_pending=4'b0110, irq=1; int_ack -> irq_src=1.
REQ-037 IRQ offered, then nmi_n falls -> grant switches: irq=0 and nmi=1 in the same cycle, with no overlap; int_ack -> nmi_pend cleared.
REQ-038 IRQ offered, line released before int_ack -> irq=0 within 3 cycles; FSM returns to IDLE and irq_src is unchanged.
REQ-039 rst_req and an NMI edge in the same cycle -> rst offered first; after int_ack plus HOLDOFF, nmi offered.
REQ-040 a_rst pulsed low during OFFER -> all outputs 0 asynchronously, irq_en=0; no request after release while irq_n is active.
